// File: rtl/game_pkg.sv
// Shared phase encoding for the game-phase controller and anything that decodes `phase`.
package game_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_RUN   = 2'd1,
        PH_PAUSE = 2'd2,
        PH_OVER  = 2'd3
    } phase_t;

    // A round is "in progress" while running or paused.
    function automatic logic is_active(input phase_t p);
        return (p == PH_RUN) || (p == PH_PAUSE);
    endfunction

endpackage

// File: rtl/sec_tick.sv
// Seconds divider: counts 0..TICK_DIV-1 while enabled and pulses `tick` on the wrap cycle.
module sec_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;
    logic          at_wrap;

    assign at_wrap = (count == CW'(TICK_DIV - 1));
    // Holding `en` low freezes the count, so a paused round resumes mid-second.
    assign tick    = en && at_wrap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// Game-phase controller: IDLE/RUN/PAUSE/OVER with lives and per-second countdown.
// Optional pause support is compiled in with `define GAME_PAUSE_EN.
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int TIME_LIMIT = 60,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pause,
    input  logic                            hit,
    output logic [1:0]                      phase,
    output logic                            gamestart,
    output logic                            paused,
    output logic                            gameover,
    output logic [$clog2(LIVES+1)-1:0]      lives_left,
    output logic [$clog2(TIME_LIMIT+1)-1:0] time_left
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = $clog2(TIME_LIMIT + 1);

    phase_t        state_q;
    phase_t        state_d;
    logic [LW-1:0] lives_d;
    logic [TW-1:0] time_d;

    logic start_q;
    logic hit_q;
    logic start_edge;
    logic hit_edge;
    logic pause_edge;

    logic tick;
    logic tick_en;
    logic tick_clr;

    // Previous-value registers reset to 0, so a level held through reset is seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            start_q <= start;
            hit_q   <= hit;
        end
    end

    assign start_edge = start && !start_q;
    assign hit_edge   = hit && !hit_q;

`ifdef GAME_PAUSE_EN
    logic pause_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    assign pause_edge = pause && !pause_q;
`else
    logic unused_pause;

    assign unused_pause = pause;
    assign pause_edge   = 1'b0;
`endif

    assign tick_en = (state_q == PH_RUN);

    sec_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_sec_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (tick_clr),
        .tick(tick)
    );

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_left;
        time_d   = time_left;
        tick_clr = 1'b0;

        case (state_q)
            PH_IDLE, PH_OVER: begin
                if (start_edge) begin
                    state_d  = PH_RUN;
                    lives_d  = LW'(LIVES);
                    time_d   = TW'(TIME_LIMIT);
                    tick_clr = 1'b1;
                end
            end
            PH_RUN: begin
                // Both decrements apply even on the cycle that ends the round.
                if (hit_edge && (lives_left != '0)) begin
                    lives_d = lives_left - LW'(1);
                end
                if (tick && (time_left != '0)) begin
                    time_d = time_left - TW'(1);
                end
                if ((hit_edge && (lives_left == LW'(1))) ||
                    (tick && (time_left == TW'(1)))) begin
                    state_d = PH_OVER;
                end else if (pause_edge) begin
                    state_d = PH_PAUSE;
                end
            end
            PH_PAUSE: begin
                if (pause_edge) begin
                    state_d = PH_RUN;
                end
            end
            default: state_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PH_IDLE;
            lives_left <= '0;
            time_left  <= '0;
            gamestart  <= 1'b0;
            gameover   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_left <= lives_d;
            time_left  <= time_d;
            gamestart  <= is_active(state_d);
            gameover   <= (state_d == PH_OVER);
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            paused <= 1'b0;
        end else begin
            paused <= (state_d == PH_PAUSE);
        end
    end
`else
    assign paused = 1'b0;
`endif

    assign phase = state_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl (LIVES=2, TIME_LIMIT=3, TICK_DIV=4) with a queue-based scoreboard.
module tb_game_phase_ctrl;

    localparam int W = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] phase;
    logic       gamestart;
    logic       paused;
    logic       gameover;
    logic [1:0] lives_left;
    logic [1:0] time_left;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    game_phase_ctrl #(
        .LIVES(2),
        .TIME_LIMIT(3),
        .TICK_DIV(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .hit       (hit),
        .phase     (phase),
        .gamestart (gamestart),
        .paused    (paused),
        .gameover  (gameover),
        .lives_left(lives_left),
        .time_left (time_left)
    );

    // Expected word: {phase, gamestart, paused, gameover, lives, time}; flags follow from phase.
    function automatic logic [W-1:0] pack(input logic [1:0] ph, input logic [1:0] lv, input logic [1:0] tm);
        logic gs;
        logic ps;
        logic go;
        gs = (ph == 2'd1) || (ph == 2'd2);
        ps = (ph == 2'd2);
        go = (ph == 2'd3);
        return {ph, gs, ps, go, lv, tm};
    endfunction

    task automatic expect_out(input string nm, input logic [1:0] ph, input logic [1:0] lv, input logic [1:0] tm);
        exp_q.push_back(pack(ph, lv, tm));
        name_q.push_back(nm);
    endtask

    task automatic step(input logic s, input logic p, input logic h);
        start = s;
        pause = p;
        hit   = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm, input logic s);
        rst = 1'b0;
        step(s, 1'b0, 1'b0);
        expect_out(nm, 2'd0, 2'd0, 2'd0);
        step(s, 1'b0, 1'b0);
        expect_out(nm, 2'd0, 2'd0, 2'd0);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] got;
        logic [W-1:0] want;
        string        nm;
        if (exp_q.size() != 0) begin
            got  = {phase, gamestart, paused, gameover, lives_left, time_left};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s @%0t: got phase=%0d gs=%0b ps=%0b go=%0b lives=%0d time=%0d, expected phase=%0d gs=%0b ps=%0b go=%0b lives=%0d time=%0d",
                         nm, $time, got[8:7], got[6], got[5], got[4], got[3:2], got[1:0],
                         want[8:7], want[6], want[5], want[4], want[3:2], want[1:0]);
            end
        end
    end

    initial begin
        // Power-up reset, then a start pulse and an uninterrupted countdown.
        do_reset("reset", 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("start_load", 2'd1, 2'd2, 2'd3);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            expect_out("countdown", (k == 12) ? 2'd3 : 2'd1, 2'd2, 2'(3 - k / 4));
        end
        step(1'b0, 1'b0, 1'b0);
        expect_out("over_hold", 2'd3, 2'd2, 2'd0);

        // Restart from OVER, two hits end the round with time untouched.
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        expect_out("hit1", 2'd1, 2'd1, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        expect_out("hit_gap", 2'd1, 2'd1, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        expect_out("hit_last", 2'd3, 2'd0, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        expect_out("over_ignores", 2'd3, 2'd0, 2'd3);
        step(1'b0, 1'b0, 1'b0);

`ifdef GAME_PAUSE_EN
        step(1'b1, 1'b0, 1'b0);
        expect_out("pause_restart", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pause_enter", 2'd2, 2'd2, 2'd3);
        for (int k = 3; k <= 11; k++) begin
            step(k == 8, 1'b0, k == 5);
            expect_out("pause_frozen", 2'd2, 2'd2, 2'd3);
        end
        step(1'b0, 1'b1, 1'b0);
        expect_out("resume", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        expect_out("resume_count", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        expect_out("first_dec", 2'd1, 2'd2, 2'd2);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pause_again", 2'd2, 2'd2, 2'd2);
        do_reset("reset_in_pause", 1'b0);
`else
        step(1'b1, 1'b0, 1'b0);
        expect_out("nopause_restart", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b1, 1'b0);
        expect_out("nopause_ignored", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("nopause_ignored2", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);
        expect_out("nopause_dec", 2'd1, 2'd2, 2'd2);
        do_reset("reset_mid_run", 1'b0);
`endif

        // IDLE ignores pause and hit.
        step(1'b0, 1'b1, 1'b1);
        expect_out("idle_ignores", 2'd0, 2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0);

        // Last life lost on the same cycle as the last second.
        step(1'b1, 1'b0, 1'b0);
        expect_out("simul_start", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        expect_out("simul_hit1", 2'd1, 2'd1, 2'd3);
        for (int k = 2; k <= 11; k++) begin
            step(1'b0, 1'b0, 1'b0);
            expect_out("simul_count", 2'd1, 2'd1, 2'(3 - k / 4));
        end
        step(1'b0, 1'b0, 1'b1);
        expect_out("simul_last", 2'd3, 2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("no_underflow", 2'd3, 2'd0, 2'd0);

        // Held start gives one restart only; held hit costs one life.
        step(1'b1, 1'b0, 1'b0);
        expect_out("held_restart", 2'd1, 2'd2, 2'd3);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, k <= 5);
            expect_out("held_buttons", (k >= 12) ? 2'd3 : 2'd1, 2'd1, (k >= 12) ? 2'd0 : 2'(3 - k / 4));
        end
        step(1'b0, 1'b0, 1'b0);
        expect_out("held_release", 2'd3, 2'd1, 2'd0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart_reload", 2'd1, 2'd2, 2'd3);

        // Reset mid-round with start held; the held level starts a round once reset lifts.
        do_reset("reset_mid_round", 1'b1);
        step(1'b1, 1'b0, 1'b0);
        expect_out("start_through_reset", 2'd1, 2'd2, 2'd3);
        step(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
